// File: rtl/fir_coef_ctrl.sv
// Coefficient SRAM sequencer for the FIR filter: serialises host reloads against
// per-sample tap fetch sweeps and presents fetched taps to the MAC.
//
// state | meaning
// IDLE  | no SRAM traffic; accepts a reload request or a fetch sweep
// LOAD  | writing host coefficient words to taps 1..NUM_TAP
// FETCH | reading taps 1..NUM_TAP for the MAC, one per cycle
module fir_coef_ctrl #(
    parameter int NUM_TAP = 10,
    parameter int DW      = 16,
    parameter int AW      = 4
) (
    input  logic          iClk_12M,
    input  logic          iRst,
    input  logic          iCoefUpdate,
    input  logic          iCoefWrVld,
    input  logic [DW-1:0] iCoefWrDt,
    output logic          oCoefWrRdy,
    input  logic          iSmpVld,
    output logic          oSmpRdy,
    output logic          oCsnRam,
    output logic          oWrnRam,
    output logic [AW-1:0] oAddrRam,
    output logic [DW-1:0] oWrDtRam,
    input  logic [DW-1:0] iRdDtRam,
    output logic [DW-1:0] oCoef,
    output logic          oCoefVld,
    output logic [AW-1:0] oCoefIdx,
    output logic          oCoefLast,
    output logic          oLoadDone,
    output logic          oBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2
    } state_t;

    localparam logic [AW-1:0] TAP_FIRST = AW'(1);
    localparam logic [AW-1:0] TAP_LAST  = AW'(NUM_TAP);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic          upd_pend;
    logic          cnt_last;
    logic          wr_en;
    logic          rd_en;

    assign cnt_last = (cnt == TAP_LAST);
    assign wr_en    = (state == LOAD) && iCoefWrVld;
    assign rd_en    = (state == FETCH);

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reload requests take priority over samples so a pending update is never starved.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (iCoefUpdate || upd_pend) begin
                    state_nxt = LOAD;
                end else if (iSmpVld) begin
                    state_nxt = FETCH;
                end
            end
            LOAD: begin
                if (iCoefWrVld && cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            cnt       <= TAP_FIRST;
            upd_pend  <= 1'b0;
            oCoefVld  <= 1'b0;
            oCoefIdx  <= '0;
            oCoefLast <= 1'b0;
            oLoadDone <= 1'b0;
        end else begin
            if (wr_en || rd_en) begin
                cnt <= cnt_last ? TAP_FIRST : cnt + TAP_FIRST;
            end
            if (state == IDLE && state_nxt == LOAD) begin
                upd_pend <= 1'b0;
            end else if (iCoefUpdate && state != IDLE) begin
                upd_pend <= 1'b1;
            end
            // SRAM read data lands one cycle after the read, so the tags trail by one.
            oCoefVld  <= rd_en;
            oCoefIdx  <= rd_en ? cnt : '0;
            oCoefLast <= rd_en && cnt_last;
            oLoadDone <= wr_en && cnt_last;
        end
    end

    always_comb begin
        oCsnRam    = !(wr_en || rd_en);
        oWrnRam    = !wr_en;
        oAddrRam   = (wr_en || rd_en) ? cnt : '0;
        oWrDtRam   = wr_en ? iCoefWrDt : '0;
        oCoefWrRdy = (state == LOAD);
        oSmpRdy    = (state == IDLE) && !upd_pend && !iCoefUpdate;
        oBusy      = (state != IDLE) || upd_pend;
        oCoef      = oCoefVld ? iRdDtRam : '0;
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Scoreboard bench for fir_coef_ctrl: a transaction-level model predicts SRAM
// traffic and handshakes each cycle and queues expected MAC taps per sweep.
module tb_fir_coef_ctrl;

    localparam int NT = 10;

    logic        clk = 1'b0;
    logic        iRst = 1'b0;
    logic        iCoefUpdate = 1'b0;
    logic        iCoefWrVld = 1'b0;
    logic [15:0] iCoefWrDt = '0;
    logic        oCoefWrRdy;
    logic        iSmpVld = 1'b0;
    logic        oSmpRdy;
    logic        oCsnRam;
    logic        oWrnRam;
    logic [3:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic [15:0] iRdDtRam;
    logic [15:0] oCoef;
    logic        oCoefVld;
    logic [3:0]  oCoefIdx;
    logic        oCoefLast;
    logic        oLoadDone;
    logic        oBusy;

    fir_coef_ctrl dut (
        .iClk_12M   (clk),
        .iRst       (iRst),
        .iCoefUpdate(iCoefUpdate),
        .iCoefWrVld (iCoefWrVld),
        .iCoefWrDt  (iCoefWrDt),
        .oCoefWrRdy (oCoefWrRdy),
        .iSmpVld    (iSmpVld),
        .oSmpRdy    (oSmpRdy),
        .oCsnRam    (oCsnRam),
        .oWrnRam    (oWrnRam),
        .oAddrRam   (oAddrRam),
        .oWrDtRam   (oWrDtRam),
        .iRdDtRam   (iRdDtRam),
        .oCoef      (oCoef),
        .oCoefVld   (oCoefVld),
        .oCoefIdx   (oCoefIdx),
        .oCoefLast  (oCoefLast),
        .oLoadDone  (oLoadDone),
        .oBusy      (oBusy)
    );

    always #42 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, cleared by its own reset
    logic [15:0] sram [0:15];
    logic [15:0] rd_q = '0;
    assign iRdDtRam = rd_q;
    always @(posedge clk) begin
        if (iRst) begin
            for (int i = 0; i < 16; i++) sram[i] <= '0;
            rd_q <= '0;
        end else if (!oCsnRam) begin
            if (!oWrnRam) sram[oAddrRam] <= oWrDtRam;
            else          rd_q <= sram[oAddrRam];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [15:0] coef;
        logic [3:0]  idx;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (transaction level)
    bit          started = 1'b0;
    bit          m_loading = 1'b0;
    bit          m_pend = 1'b0;
    int          m_words = 0;
    int          m_sweep_left = 0;
    int          done_due = -1;
    logic [15:0] ref_mem [0:15];
    bit          m_idle;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (iRst) begin
                started = 1'b1;
                m_loading = 1'b0;
                m_pend = 1'b0;
                m_words = 0;
                m_sweep_left = 0;
                done_due = -1;
                exp_q.delete();
                for (int i = 0; i < 16; i++) ref_mem[i] = '0;
            end else if (started) begin
                m_idle = !m_loading && m_sweep_left == 0;
                chk("smp_rdy", oSmpRdy, m_idle && !m_pend && !iCoefUpdate);
                chk("wr_rdy", oCoefWrRdy, m_loading);
                chk("busy", oBusy, !m_idle || m_pend);
                chk("load_done", oLoadDone, cyc == done_due);
                if (m_idle) begin
                    chk("idle_csn", oCsnRam, 1);
                    if (iCoefUpdate || m_pend) begin
                        m_loading = 1'b1;
                        m_words = 0;
                        m_pend = 1'b0;
                    end else if (iSmpVld) begin
                        for (int i = 0; i < NT; i++) begin
                            exp_t e;
                            e.due  = cyc + 2 + i;
                            e.coef = ref_mem[i + 1];
                            e.idx  = 4'(i + 1);
                            e.last = (i == NT - 1);
                            exp_q.push_back(e);
                        end
                        m_sweep_left = NT;
                    end
                end else if (m_loading) begin
                    if (iCoefUpdate) m_pend = 1'b1;
                    if (iCoefWrVld) begin
                        chk("wr_csn", oCsnRam, 0);
                        chk("wr_wrn", oWrnRam, 0);
                        chk("wr_addr", oAddrRam, m_words + 1);
                        chk("wr_data", oWrDtRam, iCoefWrDt);
                        m_words++;
                        ref_mem[m_words] = iCoefWrDt;
                        if (m_words == NT) begin
                            m_loading = 1'b0;
                            done_due = cyc + 1;
                        end
                    end else begin
                        chk("gap_csn", oCsnRam, 1);
                    end
                end else begin
                    if (iCoefUpdate) m_pend = 1'b1;
                    chk("rd_csn", oCsnRam, 0);
                    chk("rd_wrn", oWrnRam, 1);
                    chk("rd_addr", oAddrRam, NT + 1 - m_sweep_left);
                    m_sweep_left--;
                end
            end
        end
    end

    // MAC-side monitor
    initial begin
        forever begin
            @(negedge clk);
            if (started && !iRst) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("coef_vld", oCoefVld, 1);
                    chk("coef", oCoef, e.coef);
                    chk("coef_idx", oCoefIdx, e.idx);
                    chk("coef_last", oCoefLast, e.last);
                end else begin
                    chk("coef_vld_idle", oCoefVld, 0);
                    chk("coef_idle", oCoef, 0);
                end
            end
        end
    end

    logic [15:0] wbuf [0:9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output int t);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (oSmpRdy && iSmpVld) break;
        end
        if (k == 200) chk("accept_timeout", 0, 1);
        t = cyc;
        tick();
    endtask

    task automatic do_load(input bit pulse, input int n, input int gap_pos,
                           input int gap_len, input int upd_at);
        int k;
        if (pulse) begin
            iCoefUpdate = 1'b1;
            tick();
            iCoefUpdate = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (i == gap_pos) begin
                iCoefWrVld = 1'b0;
                repeat (gap_len) tick();
            end
            iCoefWrVld = 1'b1;
            iCoefWrDt  = wbuf[i];
            iCoefUpdate = (i == upd_at);
            for (k = 0; k < 200; k++) begin
                @(negedge clk);
                if (oCoefWrRdy) break;
            end
            if (k == 200) chk("wr_rdy_timeout", 0, 1);
            tick();
            iCoefUpdate = 1'b0;
        end
        iCoefWrVld = 1'b0;
        iCoefWrDt  = '0;
    endtask

    task automatic do_sweeps(input int n);
        int t0, t1;
        iSmpVld = 1'b1;
        wait_accept(t0);
        for (int s = 1; s < n; s++) begin
            wait_accept(t1);
            chk("sweep_period", t1 - t0, 11);
            t0 = t1;
        end
        iSmpVld = 1'b0;
        repeat (12) tick();
    endtask

    task automatic chk_reset_vals();
        @(negedge clk);
        chk("rst_csn", oCsnRam, 1);
        chk("rst_wrn", oWrnRam, 1);
        chk("rst_addr", oAddrRam, 0);
        chk("rst_wdata", oWrDtRam, 0);
        chk("rst_vld", oCoefVld, 0);
        chk("rst_coef", oCoef, 0);
        chk("rst_idx", oCoefIdx, 0);
        chk("rst_last", oCoefLast, 0);
        chk("rst_done", oLoadDone, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_wr_rdy", oCoefWrRdy, 0);
    endtask

    task automatic do_reset(input int n);
        iRst = 1'b1;
        iSmpVld = 1'b0;
        iCoefWrVld = 1'b0;
        iCoefUpdate = 1'b0;
        tick();
        chk_reset_vals();
        repeat (n - 1) tick();
        iRst = 1'b0;
        @(negedge clk);
        chk("smp_rdy_after_rst", oSmpRdy, 1);
        tick();
    endtask

    initial begin
        #(84 * 60000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        tick();
        do_reset(3);

        // Ramp load with a two-cycle gap after word 4, then back-to-back sweeps
        for (int i = 0; i < NT; i++) wbuf[i] = 16'(i + 1);
        do_load(1, NT, 4, 2, -1);
        tick();
        do_sweeps(2);

        // Reload requested at tap 5 of a sweep: sweep finishes on old taps
        for (int i = 0; i < NT; i++) wbuf[i] = 16'($urandom);
        iSmpVld = 1'b1;
        wait_accept(t);
        iSmpVld = 1'b0;
        repeat (4) tick();
        iCoefUpdate = 1'b1;
        tick();
        iCoefUpdate = 1'b0;
        do_load(0, NT, -1, 0, -1);
        do_sweeps(1);

        // Update and sample in the same idle cycle: load wins, sample is held
        for (int i = 0; i < NT; i++) wbuf[i] = 16'(-(i + 1));
        iSmpVld = 1'b1;
        iCoefUpdate = 1'b1;
        @(negedge clk);
        chk("collide_smp_rdy", oSmpRdy, 0);
        tick();
        iCoefUpdate = 1'b0;
        do_load(0, NT, -1, 0, -1);
        wait_accept(t);
        iSmpVld = 1'b0;
        repeat (12) tick();

        // Reset in the middle of a fetch sweep
        iSmpVld = 1'b1;
        wait_accept(t);
        iSmpVld = 1'b0;
        repeat (3) tick();
        do_reset(3);

        // Reset after six words of a load, then a full reload from address 1
        for (int i = 0; i < NT; i++) wbuf[i] = 16'($urandom);
        do_load(1, 6, -1, 0, -1);
        do_reset(1);
        for (int i = 0; i < NT; i++) wbuf[i] = 16'($urandom);
        do_load(1, NT, -1, 0, -1);
        do_sweeps(1);

        // Update during load: a second full reload follows
        for (int i = 0; i < NT; i++) wbuf[i] = 16'($urandom);
        do_load(1, NT, -1, 0, 3);
        for (int i = 0; i < NT; i++) wbuf[i] = 16'($urandom);
        do_load(0, NT, -1, 0, -1);
        do_sweeps(1);

        // Random loads and sweeps
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NT; i++) wbuf[i] = 16'($urandom);
            do_load(1, NT, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), -1);
            repeat ($urandom_range(0, 3)) tick();
            do_sweeps(int'($urandom_range(1, 3)));
        end

        repeat (15) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
